// File: rtl/vga_out_pkg.sv
// vga_out_pkg: shared constants and helpers for the VGA DAC output stage.
//   BAYER          - 2x2 ordered-dither matrix, indexed {row, col}
//   dither_thresh  - Bayer value scaled to the number of discarded bits
//   quantise       - saturating add on a left-aligned MAX_BPP-bit value
package vga_out_pkg;

    localparam int MAX_BPP = 8;

    localparam logic [1:0] BAYER [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

    // e is the number of bits dropped by the DAC (IN_BPP - OUT_BPP).
    function automatic logic [MAX_BPP-1:0] dither_thresh(input logic [1:0] idx,
                                                        input int         e);
        logic [MAX_BPP-1:0] v;
        v = MAX_BPP'(BAYER[idx]);
        if (e >= 2)
            dither_thresh = v << (e - 2);
        else if (e == 1)
            dither_thresh = v >> 1;
        else
            dither_thresh = '0;
    endfunction

    // Both operands are left-aligned to MAX_BPP bits, so a carry out of
    // bit MAX_BPP-1 is exactly "sum >= 2^IN_BPP". Saturating to all-ones
    // makes the top OUT_BPP bits all-ones; the caller keeps those bits.
    function automatic logic [MAX_BPP-1:0] quantise(input logic [MAX_BPP-1:0] val,
                                                   input logic [MAX_BPP-1:0] t);
        logic [MAX_BPP:0] sum;
        sum = {1'b0, val} + {1'b0, t};
        quantise = sum[MAX_BPP] ? {MAX_BPP{1'b1}} : sum[MAX_BPP-1:0];
    endfunction

endpackage

// File: rtl/vga_dither_chan.sv
// vga_dither_chan: one colour channel of the quantise stage.
//   i_clk_vid, i_reset, i_ce_pix - clock, async reset, pixel enable
//   i_dither_en                  - 1 adds the Bayer threshold, 0 truncates
//   i_de                         - registered data enable; 0 forces black
//   i_idx                        - Bayer index for this pixel
//   i_chan  [IN_BPP]             - captured channel value
//   o_chan  [OUT_BPP]            - registered DAC value
module vga_dither_chan
    import vga_out_pkg::*;
#(
    parameter int IN_BPP  = 8,
    parameter int OUT_BPP = 6
) (
    input  logic               i_clk_vid,
    input  logic               i_reset,
    input  logic               i_ce_pix,
    input  logic               i_dither_en,
    input  logic               i_de,
    input  logic [1:0]         i_idx,
    input  logic [IN_BPP-1:0]  i_chan,
    output logic [OUT_BPP-1:0] o_chan
);

    localparam int E     = IN_BPP - OUT_BPP;
    localparam int ALIGN = MAX_BPP - IN_BPP;

    logic [MAX_BPP-1:0] w_val_al;
    logic [MAX_BPP-1:0] w_t_al;
    logic [MAX_BPP-1:0] w_q;
    logic [OUT_BPP-1:0] r_chan;

    // Threshold is below 2^E <= 2^IN_BPP, so aligning it never overflows.
    // With E=0 dither_thresh returns 0, so dither_en has no effect.
    always_comb begin
        w_val_al = MAX_BPP'(i_chan) << ALIGN;
        w_t_al   = i_dither_en ? (dither_thresh(i_idx, E) << ALIGN) : '0;
        w_q      = quantise(w_val_al, w_t_al);
    end

    always_ff @(posedge i_clk_vid or posedge i_reset) begin
        if (i_reset)
            r_chan <= '0;
        else if (i_ce_pix)
            r_chan <= i_de ? w_q[MAX_BPP-1 -: OUT_BPP] : '0;
    end

    assign o_chan = r_chan;

endmodule

// File: rtl/vga_dac_out.sv
// vga_dac_out: two-stage VGA DAC output with ordered dithering.
//   clk_vid, reset, ce_pix        - video clock, async reset, pixel enable
//   dither_en, csync_en           - dithering / composite-sync controls
//   r_in, g_in, b_in [IN_BPP]     - pixel colour
//   hs_in, vs_in, de_in           - active-high sync and data enable
//   vga_r, vga_g, vga_b [OUT_BPP] - DAC colour
//   vga_hs, vga_vs                - active-low sync
//   vga_blank_n, vga_sync_n       - blanking and composite-sync strobes
// Colour, sync and blank share the same two registers of latency.
module vga_dac_out
    import vga_out_pkg::*;
#(
    parameter int IN_BPP  = 8,
    parameter int OUT_BPP = 6
) (
    input  logic               clk_vid,
    input  logic               reset,
    input  logic               ce_pix,
    input  logic               dither_en,
    input  logic               csync_en,
    input  logic [IN_BPP-1:0]  r_in,
    input  logic [IN_BPP-1:0]  g_in,
    input  logic [IN_BPP-1:0]  b_in,
    input  logic               hs_in,
    input  logic               vs_in,
    input  logic               de_in,
    output logic [OUT_BPP-1:0] vga_r,
    output logic [OUT_BPP-1:0] vga_g,
    output logic [OUT_BPP-1:0] vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_blank_n,
    output logic               vga_sync_n
);

    logic [IN_BPP-1:0] r_r1, r_g1, r_b1;
    logic              r_hs1, r_vs1, r_de1;
    logic              r_xpar, r_ypar, r_fpar;
    logic              r_xs1, r_ys1, r_fs1;
    logic              r_hs2, r_vs2, r_blank_n2, r_sync_n2;

    logic              w_hs_rise, w_vs_rise;
    logic [1:0]        w_idx;
    logic              w_csync;

    assign w_hs_rise = hs_in & ~r_hs1;
    assign w_vs_rise = vs_in & ~r_vs1;

    // Stage 1: capture pixel, sync and the parity phase it was sent at.
    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            r_r1   <= '0;
            r_g1   <= '0;
            r_b1   <= '0;
            r_hs1  <= 1'b0;
            r_vs1  <= 1'b0;
            r_de1  <= 1'b0;
            r_xpar <= 1'b0;
            r_ypar <= 1'b0;
            r_fpar <= 1'b0;
            r_xs1  <= 1'b0;
            r_ys1  <= 1'b0;
            r_fs1  <= 1'b0;
        end else if (ce_pix) begin
            r_r1   <= r_in;
            r_g1   <= g_in;
            r_b1   <= b_in;
            r_hs1  <= hs_in;
            r_vs1  <= vs_in;
            r_de1  <= de_in;
            r_xs1  <= r_xpar;
            r_ys1  <= r_ypar;
            r_fs1  <= r_fpar;
            r_xpar <= de_in ? ~r_xpar : 1'b0;
            // A frame start resets the line parity even if hs rises too.
            if (w_vs_rise) begin
                r_fpar <= ~r_fpar;
                r_ypar <= 1'b0;
            end else if (w_hs_rise) begin
                r_ypar <= ~r_ypar;
            end
        end
    end

    // Frame parity flips the matrix each frame for temporal dithering.
    assign w_idx   = {r_ys1 ^ r_fs1, r_xs1 ^ r_fs1};
    assign w_csync = r_hs1 ^ r_vs1;

    // Stage 2: quantise colour and drive sync/blank on the same edge.
    vga_dither_chan #(.IN_BPP(IN_BPP), .OUT_BPP(OUT_BPP)) u_chan_r (
        .i_clk_vid(clk_vid), .i_reset(reset), .i_ce_pix(ce_pix),
        .i_dither_en(dither_en), .i_de(r_de1), .i_idx(w_idx),
        .i_chan(r_r1), .o_chan(vga_r)
    );

    vga_dither_chan #(.IN_BPP(IN_BPP), .OUT_BPP(OUT_BPP)) u_chan_g (
        .i_clk_vid(clk_vid), .i_reset(reset), .i_ce_pix(ce_pix),
        .i_dither_en(dither_en), .i_de(r_de1), .i_idx(w_idx),
        .i_chan(r_g1), .o_chan(vga_g)
    );

    vga_dither_chan #(.IN_BPP(IN_BPP), .OUT_BPP(OUT_BPP)) u_chan_b (
        .i_clk_vid(clk_vid), .i_reset(reset), .i_ce_pix(ce_pix),
        .i_dither_en(dither_en), .i_de(r_de1), .i_idx(w_idx),
        .i_chan(r_b1), .o_chan(vga_b)
    );

    always_ff @(posedge clk_vid or posedge reset) begin
        if (reset) begin
            r_hs2      <= 1'b1;
            r_vs2      <= 1'b1;
            r_blank_n2 <= 1'b0;
            r_sync_n2  <= 1'b1;
        end else if (ce_pix) begin
            r_blank_n2 <= r_de1;
            if (csync_en) begin
                r_hs2     <= ~w_csync;
                r_vs2     <= 1'b1;
                r_sync_n2 <= ~w_csync;
            end else begin
                r_hs2     <= ~r_hs1;
                r_vs2     <= ~r_vs1;
                r_sync_n2 <= 1'b1;
            end
        end
    end

    assign vga_hs      = r_hs2;
    assign vga_vs      = r_vs2;
    assign vga_blank_n = r_blank_n2;
    assign vga_sync_n  = r_sync_n2;

endmodule

// File: tb/tb_vga_dac_out.sv
module tb_vga_dac_out;

    logic       clk_vid = 1'b0;
    logic       reset;
    logic       ce_pix;
    logic       dither_en;
    logic       csync_en;
    logic [7:0] r_in, g_in, b_in;
    logic       hs_in, vs_in, de_in;
    logic [5:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank_n, vga_sync_n;

    int n_chk = 0;
    int n_err = 0;

    vga_dac_out #(.IN_BPP(8), .OUT_BPP(6)) dut (
        .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix),
        .dither_en(dither_en), .csync_en(csync_en),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_in(hs_in), .vs_in(vs_in), .de_in(de_in),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n)
    );

    always #5 clk_vid = ~clk_vid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_vid);
        #1;
    endtask

    task automatic drv(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                       input logic hs, input logic vs, input logic de);
        r_in  = r;
        g_in  = g;
        b_in  = b;
        hs_in = hs;
        vs_in = vs;
        de_in = de;
    endtask

    initial begin
        reset     = 1'b1;
        ce_pix    = 1'b1;
        dither_en = 1'b0;
        csync_en  = 1'b0;
        drv(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        // Reset state
        chk("rst_r",       32'(vga_r),       32'h0);
        chk("rst_g",       32'(vga_g),       32'h0);
        chk("rst_b",       32'(vga_b),       32'h0);
        chk("rst_hs",      32'(vga_hs),      32'h1);
        chk("rst_vs",      32'(vga_vs),      32'h1);
        chk("rst_blank_n", 32'(vga_blank_n), 32'h0);
        chk("rst_sync_n",  32'(vga_sync_n),  32'h1);
        reset = 1'b0;

        // Plain truncation, 2-cycle latency
        drv(8'hFF, 8'h80, 8'h03, 1'b0, 1'b0, 1'b1);
        tick();
        chk("lat1_blank_n", 32'(vga_blank_n), 32'h0);
        tick();
        chk("trunc_r",       32'(vga_r),       32'h3F);
        chk("trunc_g",       32'(vga_g),       32'h20);
        chk("trunc_b",       32'(vga_b),       32'h00);
        chk("trunc_blank_n", 32'(vga_blank_n), 32'h1);
        chk("trunc_hs",      32'(vga_hs),      32'h1);
        drv(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();

        // Frame 0, line 0: thresholds 0,2,0,2 on value 2
        dither_en = 1'b1;
        drv(8'h02, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        tick(); chk("f0l0_x0", 32'(vga_r), 32'h0);
        tick(); chk("f0l0_x1", 32'(vga_r), 32'h1);
        tick(); chk("f0l0_x2", 32'(vga_r), 32'h0);
        tick(); chk("f0l0_x3", 32'(vga_r), 32'h1);

        // Blank with hs asserted (also starts line 1)
        drv(8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        chk("blank_r",       32'(vga_r),       32'h0);
        chk("blank_blank_n", 32'(vga_blank_n), 32'h0);
        chk("blank_hs",      32'(vga_hs),      32'h0);
        chk("blank_vs",      32'(vga_vs),      32'h1);
        chk("blank_sync_n",  32'(vga_sync_n),  32'h1);
        drv(8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();

        // Frame 0, line 1: thresholds 3,1,3,1, with a 5-cycle ce stall
        drv(8'h02, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        tick(); chk("f0l1_x0", 32'(vga_r), 32'h1);
        tick(); chk("f0l1_x1", 32'(vga_r), 32'h0);
        ce_pix = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("freeze_r",       32'(vga_r),       32'h0);
            chk("freeze_blank_n", 32'(vga_blank_n), 32'h1);
        end
        ce_pix = 1'b1;
        tick(); chk("f0l1_x2", 32'(vga_r), 32'h1);
        tick(); chk("f0l1_x3", 32'(vga_r), 32'h0);

        // Composite sync: hs and vs rise together (new frame, line parity cleared)
        csync_en = 1'b1;
        drv(8'hFF, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        tick(); tick();
        chk("cs_both_hs",     32'(vga_hs),      32'h1);
        chk("cs_both_vs",     32'(vga_vs),      32'h1);
        chk("cs_both_sync_n", 32'(vga_sync_n),  32'h1);
        chk("cs_both_r",      32'(vga_r),       32'h0);
        drv(8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        chk("cs_hs_hs",     32'(vga_hs),     32'h0);
        chk("cs_hs_vs",     32'(vga_vs),     32'h1);
        chk("cs_hs_sync_n", 32'(vga_sync_n), 32'h0);
        csync_en = 1'b0;
        drv(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        chk("sep_idle_hs",     32'(vga_hs),     32'h1);
        chk("sep_idle_sync_n", 32'(vga_sync_n), 32'h1);

        // Frame 1, line 0: thresholds 1,3,1,3 on value 3
        drv(8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        tick(); chk("f1l0_x0", 32'(vga_r), 32'h1);
        tick(); chk("f1l0_x1", 32'(vga_r), 32'h1);
        tick(); chk("f1l0_x2", 32'(vga_r), 32'h1);
        drv(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        drv(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();

        // Frame 1, line 1: thresholds 2,0 on 0xFE -> saturate, no wrap
        drv(8'hFE, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        tick(); chk("sat_x0", 32'(vga_r), 32'h3F);
        tick(); chk("sat_x1", 32'(vga_r), 32'h3F);

        // Separate vsync output
        drv(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        tick(); tick();
        chk("sep_vs_vs", 32'(vga_vs), 32'h0);
        chk("sep_vs_hs", 32'(vga_hs), 32'h1);
        drv(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();

        // Asynchronous reset mid-line
        dither_en = 1'b0;
        drv(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b1);
        tick(); tick();
        chk("pre_rst_r", 32'(vga_r), 32'h3F);
        chk("pre_rst_g", 32'(vga_g), 32'h3F);
        #2 reset = 1'b1;
        #1;
        chk("arst_r",       32'(vga_r),       32'h0);
        chk("arst_g",       32'(vga_g),       32'h0);
        chk("arst_blank_n", 32'(vga_blank_n), 32'h0);
        chk("arst_hs",      32'(vga_hs),      32'h1);
        chk("arst_vs",      32'(vga_vs),      32'h1);
        chk("arst_sync_n",  32'(vga_sync_n),  32'h1);
        #1 reset = 1'b0;

        // Dither phase restarts at (0,0,0): thresholds 0,2 on value 3
        dither_en = 1'b1;
        drv(8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        chk("post_rst_lat", 32'(vga_blank_n), 32'h0);
        tick(); chk("post_rst_x0", 32'(vga_r), 32'h0);
        tick(); chk("post_rst_x1", 32'(vga_r), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
